tiger_debug_mbox: RTL
=====================

TIGER_DEBUG_MBOX -- requirements
Module: tiger_debug_mbox

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of debug channels (legal range 1..16).
REQ-002 SHALL have parameter DATA_W, default 8, payload bits per message (legal range 1..16).
REQ-003 SHALL define CH_W = max(1, clog2(NUM_CH)) and SR_W = CH_W + DATA_W.
REQ-004 clk  in  1  Avalon-side clock.
REQ-005 reset_n  in  1  asynchronous, active-low reset for both clock domains.
REQ-006 tck  in  1  JTAG-side clock.
REQ-007 tdi  in  1  JTAG serial data.
REQ-008 sdr  in  1  virtual JTAG shift-DR state.
REQ-009 udr  in  1  virtual JTAG update-DR state.
REQ-010 tdo  out  1  current shift-register bit 0.
REQ-011 avs_address  in  2  register select: 0 STATUS, 1 MASK, 2 SEL, 3 DATA.
REQ-012 avs_read / avs_write  in  1 each  Avalon strobes.
REQ-013 avs_writedata  in  32  write data; avs_readdata  out  32  read data.
REQ-014 avs_irq  out  1  registered interrupt request.

Function
REQ-015 tck domain: while sdr=1, each posedge tck SHALL shift sr <= {tdi, sr[SR_W-1:1]}; sr[CH_W-1:0] = channel, upper bits = payload.
REQ-016 On posedge tck with udr=1 and no transfer pending (req == ack_sync2), SHALL copy sr into hold register and toggle req.
REQ-017 On udr with a transfer pending, the message SHALL be discarded; hold and req SHALL stay unchanged.
REQ-018 Channel field >= NUM_CH SHALL be discarded on the clk side, but ack SHALL still toggle.
REQ-019 clk domain: req SHALL pass through 2 flops; an edge between req_sync2 and its previous value SHALL capture hold into data[ch] and toggle ack in the same cycle.
REQ-020 ack SHALL pass through 2 tck flops to form ack_sync2; hold SHALL be stable from req toggle until ack_sync2 matches.
REQ-021 Capture SHALL set pending[ch]; if pending[ch] was already 1, SHALL also set overrun[ch].
REQ-022 STATUS read: bits[NUM_CH-1:0] = pending, bits[16+NUM_CH-1:16] = overrun, others 0; write-1-to-clear on both fields.
REQ-023 MASK: r/w, bits[NUM_CH-1:0]; SEL: r/w, bits[CH_W-1:0]; unused bits read 0.
REQ-024 DATA read SHALL return zero-extended data[SEL] and clear pending[SEL]; DATA writes SHALL be ignored.
REQ-025 avs_readdata SHALL be registered; it is valid exactly 1 clk after avs_read (fixed latency 1).
REQ-026 avs_irq SHALL equal |(pending & MASK), registered 1 clk.
REQ-027 Capture and clear of the same channel in the same cycle SHALL leave pending=1; a DATA read in that cycle SHALL return the old data.
REQ-028 Simultaneous avs_read and avs_write SHALL perform the write; readdata SHALL be 0.

Reset
REQ-029 reset_n low SHALL asynchronously clear sr, hold, req, ack and all synchroniser flops, data[], pending, overrun, SEL, readdata and avs_irq; MASK SHALL reset to all ones.
REQ-030 Reset mid-transfer SHALL leave req == ack and no spurious capture after release.

Structure
REQ-031 Package tiger_debug_pkg SHALL hold register address constants, STATUS field offsets (0, 16) and the CH_W function.
REQ-032 A 2-flop synchroniser sub-module tiger_cdc_sync (async reset to 0) SHALL be instantiated for req and ack.

Verification
REQ-033 Shift ch=2, payload 0xA5, pulse udr, MASK=0xF -> within 6 clk: STATUS=0x4, avs_irq=1; DATA read with SEL=2 -> 0xA5, then STATUS=0, avs_irq=0.
REQ-034 Two messages to ch 1 without read -> STATUS=0x00020002; write 0x00020002 to STATUS -> STATUS=0.
REQ-035 Second udr before ack returns -> only the first message captured; sr reload after ack -> second capture succeeds.
REQ-036 MASK=0, message to ch 0 -> pending=1, avs_irq=0; MASK=1 -> avs_irq=1 next clk.
REQ-037 STATUS W1C of ch 3 in the same cycle as capture to ch 3 -> pending[3]=1; reset_n pulsed mid-handshake -> all registers 0, MASK=0xF, no capture afterwards.
REQ-038 NUM_CH=1, DATA_W=16: payload 0xBEEF to ch 0 -> DATA reads 0x0000BEEF.

Source files
------------

// File: rtl/tiger_debug_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tiger_debug_pkg
//  Description : Shared constants for the tiger debug mailbox: Avalon register
//                addresses, STATUS field offsets and the channel-field width
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tiger_debug_pkg;

    // Avalon register map (word addresses)
    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_SEL    = 2'd2;
    localparam logic [1:0] ADDR_DATA   = 2'd3;

    // STATUS layout: pending flags at bit 0, overrun flags at bit 16
    localparam int STATUS_PEND_LSB = 0;
    localparam int STATUS_OVR_LSB  = 16;

    // Channel field width: max(1, clog2(num_ch))
    function automatic int ch_width(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tiger_cdc_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tiger_cdc_sync
//  Description : Two-flop single-bit synchroniser, asynchronously reset to 0.
//  Ports       : clk      - destination clock
//                reset_n  - asynchronous active-low reset
//                d_i      - asynchronous input bit
//                q_o      - synchronised output bit
//  Revision    : 1.0 - initial release
// ============================================================================
module tiger_cdc_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/tiger_debug_mbox.sv
`default_nettype none
// ============================================================================
//  Module      : tiger_debug_mbox
//  Description : JTAG-to-Avalon debug mailbox. A virtual-JTAG shift register
//                carries {payload, channel} messages; each completed update
//                is handed across to the clk domain with a toggle req/ack
//                handshake and latched into a per-channel data register with
//                pending/overrun flags and a maskable interrupt.
//  Ports       : clk, reset_n           - Avalon clock, async active-low reset
//                tck, tdi, sdr, udr     - virtual JTAG clock/data/states
//                tdo                    - shift-register bit 0
//                avs_address/read/write/writedata/readdata - Avalon slave
//                avs_irq                - registered interrupt request
//  Revision    : 1.0 - initial release
// ============================================================================
module tiger_debug_mbox
    import tiger_debug_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tck,
    input  logic        tdi,
    input  logic        sdr,
    input  logic        udr,
    output logic        tdo,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_irq
);

    localparam int CH_W = ch_width(NUM_CH);
    localparam int SR_W = CH_W + DATA_W;

    // ------------------------------------------------------------------
    // tck domain: shift register, hold register and request toggle
    // ------------------------------------------------------------------
    logic [SR_W-1:0] sr_q;
    logic [SR_W-1:0] hold_q;
    logic            req_q;
    logic            ack_q;
    logic            ack_sync2;

    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            sr_q   <= '0;
            hold_q <= '0;
            req_q  <= 1'b0;
        end else begin
            if (sdr) begin
                sr_q <= {tdi, sr_q[SR_W-1:1]};
            end
            // A new update is accepted only once the previous one has been
            // acknowledged; otherwise it is dropped so hold stays stable.
            if (udr && (req_q == ack_sync2)) begin
                hold_q <= sr_q;
                req_q  <= ~req_q;
            end
        end
    end

    assign tdo = sr_q[0];

    tiger_cdc_sync u_ack_sync (
        .clk     (tck),
        .reset_n (reset_n),
        .d_i     (ack_q),
        .q_o     (ack_sync2)
    );

    // ------------------------------------------------------------------
    // clk domain: request detection and capture
    // ------------------------------------------------------------------
    logic req_sync2;
    logic req_prev_q;
    logic capture;

    tiger_cdc_sync u_req_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (req_q),
        .q_o     (req_sync2)
    );

    assign capture = req_sync2 ^ req_prev_q;

    // hold_q is quasi-static here: it only changes after ack has returned.
    logic [CH_W-1:0]   msg_ch;
    logic [DATA_W-1:0] msg_payload;
    assign msg_ch      = hold_q[CH_W-1:0];
    assign msg_payload = hold_q[SR_W-1:CH_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_prev_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            req_prev_q <= req_sync2;
            // Ack toggles even for an out-of-range channel so the JTAG side
            // never stalls on a bad message.
            if (capture) begin
                ack_q <= ~ack_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] data_q [NUM_CH];
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] overrun_q, overrun_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [31:0]       readdata_q, readdata_d;
    logic              irq_q;

    logic              wr_en;
    logic              rd_en;
    logic [NUM_CH-1:0] set_vec;
    logic [NUM_CH-1:0] sel_hit;
    logic [NUM_CH-1:0] clr_pend;
    logic [NUM_CH-1:0] clr_ovr;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        // A simultaneous read and write is treated as a write only.
        wr_en      = avs_write;
        rd_en      = avs_read && !avs_write;
        set_vec    = '0;
        sel_hit    = '0;
        sel_data   = '0;
        clr_pend   = '0;
        clr_ovr    = '0;
        mask_d     = mask_q;
        sel_d      = sel_q;
        readdata_d = '0;

        // Channel decode by comparison so channels >= NUM_CH match nothing.
        for (int i = 0; i < NUM_CH; i++) begin
            if (capture && (int'(msg_ch) == i)) begin
                set_vec[i] = 1'b1;
            end
            if (int'(sel_q) == i) begin
                sel_hit[i] = 1'b1;
                sel_data   = data_q[i];
            end
        end

        if (wr_en) begin
            case (avs_address)
                ADDR_STATUS: begin
                    clr_pend = avs_writedata[STATUS_PEND_LSB +: NUM_CH];
                    clr_ovr  = avs_writedata[STATUS_OVR_LSB +: NUM_CH];
                end
                ADDR_MASK: mask_d = avs_writedata[NUM_CH-1:0];
                ADDR_SEL:  sel_d  = avs_writedata[CH_W-1:0];
                default: ;
            endcase
        end

        if (rd_en) begin
            case (avs_address)
                ADDR_STATUS: begin
                    readdata_d[STATUS_PEND_LSB +: NUM_CH] = pending_q;
                    readdata_d[STATUS_OVR_LSB +: NUM_CH]  = overrun_q;
                end
                ADDR_MASK: readdata_d[NUM_CH-1:0] = mask_q;
                ADDR_SEL:  readdata_d[CH_W-1:0]   = sel_q;
                ADDR_DATA: begin
                    readdata_d[DATA_W-1:0] = sel_data;
                    clr_pend               = sel_hit;
                end
                default: ;
            endcase
        end

        // Set wins over clear so a capture is never lost.
        pending_d = (pending_q & ~clr_pend) | set_vec;
        overrun_d = (overrun_q & ~clr_ovr) | (set_vec & pending_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                data_q[i] <= '0;
            end
            pending_q  <= '0;
            overrun_q  <= '0;
            mask_q     <= '1;
            sel_q      <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (set_vec[i]) begin
                    data_q[i] <= msg_payload;
                end
            end
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            mask_q     <= mask_d;
            sel_q      <= sel_d;
            readdata_q <= readdata_d;
            irq_q      <= |(pending_q & mask_q);
        end
    end

    assign avs_readdata = readdata_q;
    assign avs_irq      = irq_q;

    // Upper write-data bits have no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata;

endmodule
`default_nettype wire
